// File: rtl/clk_gate_if.sv
// Handshake bundle between the gated block / wake requesters and the clock-gate enable controller.
// The master drives activity and requests; the slave (controller) drives the gate enable and status.
interface clk_gate_if;
  logic busy;
  logic wake_req;
  logic clk_disable;
  logic clk_en;
  logic wake_ack;
  logic gate_off;

  modport master (
    output busy,
    output wake_req,
    output clk_disable,
    input  clk_en,
    input  wake_ack,
    input  gate_off
  );

  modport slave (
    input  busy,
    input  wake_req,
    input  clk_disable,
    output clk_en,
    output wake_ack,
    output gate_off
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Enable controller for a glitch-less clock gate cell: gates off after an idle period,
// restores the clock on demand, and acknowledges wake requests once the clock has settled.
module clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  clk_gate_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [CNT_W-1:0] wake_cnt, wake_cnt_nxt;
  logic             ack_done, ack_done_nxt;
  logic             wake_ack_q, wake_ack_nxt;
  logic             clk_en_q, clk_en_nxt;
  logic             gate_off_q, gate_off_nxt;
  logic             idle_c;

  assign idle_c = !bus.busy && !bus.wake_req;

  // State and registered outputs; reset leaves the clock running.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_RUN;
      idle_cnt   <= '0;
      wake_cnt   <= '0;
      ack_done   <= 1'b0;
      wake_ack_q <= 1'b0;
      clk_en_q   <= 1'b1;
      gate_off_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      idle_cnt   <= idle_cnt_nxt;
      wake_cnt   <= wake_cnt_nxt;
      ack_done   <= ack_done_nxt;
      wake_ack_q <= wake_ack_nxt;
      clk_en_q   <= clk_en_nxt;
      gate_off_q <= gate_off_nxt;
    end
  end

  // Next-state and next-output logic; clk_disable overrides every other transition.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    wake_cnt_nxt = wake_cnt;
    ack_done_nxt = ack_done;
    wake_ack_nxt = 1'b0;

    if (bus.clk_disable) begin
      state_nxt    = ST_OFF;
      idle_cnt_nxt = '0;
      wake_cnt_nxt = '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (idle_c) begin
            if (idle_cnt == IDLE_LAST) begin
              state_nxt    = ST_OFF;
              idle_cnt_nxt = '0;
            end else begin
              idle_cnt_nxt = idle_cnt + CNT_ONE;
            end
          end else begin
            idle_cnt_nxt = '0;
          end
          // One ack per request: a held request must drop before it can be acked again.
          if (bus.wake_req && !ack_done) begin
            wake_ack_nxt = 1'b1;
            ack_done_nxt = 1'b1;
          end else if (!bus.wake_req) begin
            ack_done_nxt = 1'b0;
          end
        end
        ST_OFF: begin
          if (bus.busy || bus.wake_req) begin
            state_nxt    = ST_WAKE;
            wake_cnt_nxt = '0;
          end
        end
        ST_WAKE: begin
          if (wake_cnt == WAKE_LAST) begin
            state_nxt    = ST_RUN;
            wake_cnt_nxt = '0;
            idle_cnt_nxt = '0;
            wake_ack_nxt = bus.wake_req;
            ack_done_nxt = bus.wake_req;
          end else begin
            wake_cnt_nxt = wake_cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt    = ST_RUN;
          idle_cnt_nxt = '0;
          wake_cnt_nxt = '0;
        end
      endcase
    end

    clk_en_nxt   = (state_nxt != ST_OFF);
    gate_off_nxt = (state_nxt == ST_OFF);
  end

  assign bus.clk_en   = clk_en_q;
  assign bus.wake_ack = wake_ack_q;
  assign bus.gate_off = gate_off_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl (IDLE_CYCLES=4, WAKE_CYCLES=2): each driven cycle pushes the
// expected post-edge outputs; a monitor pops and compares one entry after every rising edge.
module tb_clk_gate_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  clk_gate_if bus ();

  clk_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .CNT_W(8)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  en;
    logic  off;
    logic  ack;
    string name;
  } exp_t;

  exp_t exp_q[$];

  task automatic check_now(input string name, input logic en, input logic off, input logic ack);
    n_tests++;
    if (bus.clk_en !== en || bus.gate_off !== off || bus.wake_ack !== ack) begin
      n_fail++;
      $display("FAIL %s: got en=%b off=%b ack=%b, want en=%b off=%b ack=%b",
               name, bus.clk_en, bus.gate_off, bus.wake_ack, en, off, ack);
    end
  endtask

  // Called at a falling edge: drive inputs, queue the outputs expected after the next rising edge.
  task automatic cyc(input logic b, input logic w, input logic d,
                     input logic en, input logic off, input logic ack, input string name);
    exp_t e;
    bus.busy        = b;
    bus.wake_req    = w;
    bus.clk_disable = d;
    e.en = en; e.off = off; e.ack = ack; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one comparison per rising edge while expectations are queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now(e.name, e.en, e.off, e.ack);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.busy        = 1'b0;
    bus.wake_req    = 1'b0;
    bus.clk_disable = 1'b0;
    rst             = 1'b1;
    repeat (2) @(negedge clk);
    check_now("reset_hold", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Idle-off after 4 post-reset edges
    cyc(0, 0, 0, 1, 0, 0, "idle_e1");
    cyc(0, 0, 0, 1, 0, 0, "idle_e2");
    cyc(0, 0, 0, 1, 0, 0, "idle_e3");
    cyc(0, 0, 0, 0, 1, 0, "idle_off");
    cyc(0, 0, 0, 0, 1, 0, "off_stay");

    // Busy wake: WAKE for 2 cycles, no ack, then gate off after 4 idle edges
    cyc(1, 0, 0, 1, 0, 0, "bwake_enter");
    cyc(0, 0, 0, 1, 0, 0, "bwake_hold");
    cyc(0, 0, 0, 1, 0, 0, "bwake_run_noack");
    cyc(0, 0, 0, 1, 0, 0, "bwake_idle1");
    cyc(0, 0, 0, 1, 0, 0, "bwake_idle2");
    cyc(0, 0, 0, 1, 0, 0, "bwake_idle3");
    cyc(0, 0, 0, 0, 1, 0, "bwake_reoff");

    // Wake handshake from OFF
    cyc(0, 1, 0, 1, 0, 0, "hs_wake_enter");
    cyc(0, 1, 0, 1, 0, 0, "hs_wake_hold");
    cyc(0, 1, 0, 1, 0, 1, "hs_ack");
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0, 0, "hs_held_noack");
    cyc(0, 0, 0, 1, 0, 0, "hs_drop");
    cyc(0, 1, 0, 1, 0, 1, "hs_reraise_ack");
    cyc(0, 1, 0, 1, 0, 0, "hs_reraise_single");

    // Idle interrupt: 3 idle, busy on the threshold edge, then 4 more idle edges
    cyc(0, 0, 0, 1, 0, 0, "intr_idle1");
    cyc(0, 0, 0, 1, 0, 0, "intr_idle2");
    cyc(0, 0, 0, 1, 0, 0, "intr_idle3");
    cyc(1, 0, 0, 1, 0, 0, "intr_busy_at_thresh");
    cyc(0, 0, 0, 1, 0, 0, "intr_again1");
    cyc(0, 0, 0, 1, 0, 0, "intr_again2");
    cyc(0, 0, 0, 1, 0, 0, "intr_again3");
    cyc(0, 0, 0, 0, 1, 0, "intr_off");

    // clk_disable during WAKE with wake_req pending, then release
    cyc(0, 1, 0, 1, 0, 0, "dis_wake_enter");
    cyc(0, 1, 1, 0, 1, 0, "dis_force_off");
    cyc(0, 1, 1, 0, 1, 0, "dis_hold_noack");
    cyc(0, 1, 0, 1, 0, 0, "dis_release_wake");
    cyc(0, 1, 0, 1, 0, 0, "dis_wake_hold");
    cyc(0, 1, 0, 1, 0, 1, "dis_late_ack");
    cyc(0, 0, 0, 1, 0, 0, "dis_idle1");
    cyc(0, 0, 0, 1, 0, 0, "dis_idle2");
    cyc(0, 0, 0, 1, 0, 0, "dis_idle3");
    cyc(0, 0, 0, 0, 1, 0, "dis_reoff");

    // Async reset asserted between edges while OFF
    #2;
    rst = 1'b1;
    #1;
    check_now("async_rst_immediate", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_now("async_rst_held", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1, 0, 1, 0, 1, "post_rst_ack");
    @(negedge clk);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
